// File: rtl/shift_serializer.sv
// Framed parallel-to-serial output stage.
// Sends a start bit, WIDTH data bits in either order, then a stop bit.
module shift_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  input  logic             r_l,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             div_last;
  logic             bit_last;

  assign div_last = (div_cnt == DW'(DIV - 1));
  assign bit_last = (bit_cnt == BW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    sout     = 1'b1;
    busy     = 1'b1;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        ready = rst_n;
        if (valid) state_nx = START;
      end
      START: begin
        sout = 1'b0;
        if (div_last) state_nx = DATA;
      end
      DATA: begin
        sout = dir ? shreg[0] : shreg[WIDTH-1];
        if (div_last && bit_last) state_nx = STOP;
      end
      STOP: begin
        if (div_last) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      dir     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == STOP) && div_last;
      if (state == IDLE) begin
        if (valid) begin
          shreg   <= data_in;
          dir     <= r_l;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else begin
        div_cnt <= div_last ? '0 : div_cnt + DW'(1);
        // Shift toward the output end once each data bit has been held.
        if (state == DATA && div_last) begin
          shreg   <= dir ? (shreg >> 1) : (shreg << 1);
          bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer.
// Two instances: DIV=4 for most frames, DIV=1 for back-to-back.
module tb_shift_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data4, data1;
  logic       valid4, valid1;
  logic       rl4, rl1;
  logic       ready4, sout4, busy4, done4;
  logic       ready1, sout1, busy1, done1;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(8), .DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data4),
    .valid(valid4), .r_l(rl4), .ready(ready4),
    .sout(sout4), .busy(busy4), .done(done4)
  );

  shift_serializer #(.WIDTH(8), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data1),
    .valid(valid1), .r_l(rl1), .ready(ready1),
    .sout(sout1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int fails  = 0;

  // Expected data bits in line order: bit 7 goes out first.
  logic [7:0]  q4[$];
  logic [7:0]  q1[$];
  logic [79:0] cap [2];
  int          cnt [2];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: captures each frame while busy, checks it at done.
  initial begin
    cap[0] = '0; cap[1] = '0;
    cnt[0] = 0;  cnt[1] = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        s, b, dn, r;
      int          dv, pos;
      logic [7:0]  seq;
      logic [79:0] ev;
      s  = d ? sout1  : sout4;
      b  = d ? busy1  : busy4;
      dn = d ? done1  : done4;
      r  = d ? ready1 : ready4;
      dv = d ? 1 : 4;
      if (rst_n !== 1'b1) begin
        cnt[d] = 0;
        cap[d] = '0;
      end else begin
        if (b === 1'b1) begin
          if (cnt[d] < 80) cap[d][cnt[d]] = s;
          cnt[d]++;
        end
        if (dn === 1'b1) begin
          if ((d ? q1.size() : q4.size()) == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done dut%0d: got done expected none", d);
          end else begin
            seq = d ? q1.pop_front() : q4.pop_front();
            ev  = '0;
            for (int i = 0; i < 10 * dv; i++) begin
              pos = i / dv;
              if (pos == 0)      ev[i] = 1'b0;
              else if (pos <= 8) ev[i] = seq[8-pos];
              else               ev[i] = 1'b1;
            end
            chk("frame_len", cnt[d], 10 * dv);
            checks++;
            if (cap[d] !== ev) begin
              fails++;
              $display("FAIL frame_bits dut%0d: got %h expected %h",
                       d, cap[d], ev);
            end
            chk("done_cycle", {s, r, b}, 3'b110);
          end
          cnt[d] = 0;
          cap[d] = '0;
        end
      end
    end
  end

  task automatic send4(input logic [7:0] d, input logic rl);
    int n;
    n = 0;
    data4  = d;
    rl4    = rl;
    valid4 = 1'b1;
    while (ready4 !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (ready4 !== 1'b1) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 valid4 = 1'b0;
  endtask

  task automatic wait_done4(input int start, output int n);
    n = start;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done4 === 1'b1) break;
    end
    if (done4 !== 1'b1) chk("done4_timeout", 0, 1);
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done1 === 1'b1) break;
    end
    if (done1 !== 1'b1) chk("done1_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    valid4 = 1'b1;
    valid1 = 1'b1;
    data4  = 8'h5A;
    data1  = 8'h5A;
    rl4    = 1'b1;
    rl1    = 1'b1;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out4", {sout4, ready4, busy4, done4}, 4'b1000);
      chk("rst_out1", {sout1, ready1, busy1, done1}, 4'b1000);
    end
    rst_n  = 1'b1;
    valid4 = 1'b0;
    valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rel_ready", {ready4, ready1, sout4, busy4}, 4'b1110);

    // LSB first 8'hA5
    q4.push_back(8'b10100101);
    send4(8'hA5, 1'b1);
    @(negedge clk);
    chk("start_n1", {sout4, busy4, ready4}, 3'b010);
    wait_done4(1, n);
    chk("done_at_n41", n, 41);

    // MSB first 8'h01, inputs disturbed mid-frame
    q4.push_back(8'b00000001);
    send4(8'h01, 1'b0);
    repeat (12) @(negedge clk);
    rl4   = 1'b1;
    data4 = 8'hFF;
    wait_done4(12, n);
    chk("msb_len", n, 41);

    // Valid pulse during DATA is ignored
    q4.push_back(8'b01011010);
    send4(8'h5A, 1'b1);
    repeat (14) @(negedge clk);
    data4  = 8'hFF;
    valid4 = 1'b1;
    chk("busy_ready", ready4, 1'b0);
    @(negedge clk);
    valid4 = 1'b0;
    wait_done4(15, n);
    repeat (45) @(negedge clk);
    chk("no_extra", {busy4, sout4}, 2'b01);

    // Reset during data bit 3
    send4(8'hC3, 1'b1);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst", {sout4, ready4, busy4, done4}, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_idle", {sout4, ready4, busy4}, 3'b110);
    q4.push_back(8'b00111100);
    send4(8'h3C, 1'b0);
    wait_done4(0, n);
    chk("rec_len", n, 41);

    // Back-to-back on DIV=1 with valid held high
    q1.push_back(8'b00000001);
    q1.push_back(8'b10000000);
    @(negedge clk);
    data1  = 8'h80;
    rl1    = 1'b1;
    valid1 = 1'b1;
    n = 0;
    while (ready1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready", ready1, 1'b1);
    @(posedge clk);
    #1 data1 = 8'h01;
    wait_done1(n);
    chk("b2b_len1", n, 11);
    chk("b2b_gap", {sout1, ready1, busy1}, 3'b110);
    @(negedge clk);
    chk("b2b_start", {sout1, busy1, ready1}, 3'b010);
    valid1 = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done1 === 1'b1) break;
    end
    chk("b2b_len2", n, 11);

    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queues_empty", q4.size() + q1.size(), 0);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
